// File: rtl/tl_pipe_stage.sv
// Elastic EXE->TL pipeline stage: DEPTH-entry in-order buffer with valid/ready on both sides,
// load/store classification at push time and synchronous kill. Optional TL_PIPE_PERF_EN adds a stall counter.
module tl_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 2
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 kill_i,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    input  logic [31:0]          up_instr_i,
    input  logic [XLEN-1:0]      up_pc_i,
    input  logic [4:0]           up_wr_addr_i,
    input  logic                 up_wr_en_i,
    input  logic [PAYLOAD_W-1:0] up_payload_i,
    output logic                 dn_valid_o,
    input  logic                 dn_ready_i,
    output logic [31:0]          dn_instr_o,
    output logic [XLEN-1:0]      dn_pc_o,
    output logic [4:0]           dn_wr_addr_o,
    output logic                 dn_wr_en_o,
    output logic                 dn_cache_en_o,
    output logic                 dn_is_store_o,
    output logic [PAYLOAD_W-1:0] dn_payload_o,
`ifdef TL_PIPE_PERF_EN
    output logic [31:0]          stall_cnt_o,
`endif
    output logic [2:0]           occupancy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0]          instr;
        logic [XLEN-1:0]      pc;
        logic [4:0]           wr_addr;
        logic                 wr_en;
        logic                 cache_en;
        logic                 is_store;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [2:0]       count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on count alone, so a full buffer never accepts even if it pops this cycle.
    assign up_ready_o  = (count < 3'(DEPTH));
    assign dn_valid_o  = (count != 3'd0);
    assign occupancy_o = count;
    assign push        = up_valid_i && up_ready_o;
    assign pop         = dn_valid_o && dn_ready_i;

    always_comb begin
        in_entry          = '0;
        in_entry.instr    = up_instr_i;
        in_entry.pc       = up_pc_i;
        in_entry.wr_addr  = up_wr_addr_i;
        in_entry.payload  = up_payload_i;
        case (up_instr_i[6:0])
            OP_LOAD: begin
                in_entry.cache_en = 1'b1;
                in_entry.wr_en    = up_wr_en_i && (up_wr_addr_i != 5'd0);
            end
            OP_STORE: begin
                in_entry.cache_en = 1'b1;
                in_entry.is_store = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (kill_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Empty buffer drives zeros so stale entries never leak downstream.
    always_comb begin
        head = '0;
        if (dn_valid_o) head = mem[rd_ptr];
    end

    assign dn_instr_o    = head.instr;
    assign dn_pc_o       = head.pc;
    assign dn_wr_addr_o  = head.wr_addr;
    assign dn_wr_en_o    = head.wr_en;
    assign dn_cache_en_o = head.cache_en;
    assign dn_is_store_o = head.is_store;
    assign dn_payload_o  = head.payload;

`ifdef TL_PIPE_PERF_EN
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            stall_cnt_o <= '0;
        end else if (dn_valid_o && !dn_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tl_pipe_stage.sv
// Bench for tl_pipe_stage: classification table, hand sequences for reset/back-pressure/streaming/kill,
// and a randomized run against a queue model. Define TL_PIPE_PERF_EN to also cover the stall counter.
module tb_tl_pipe_stage;
    localparam int XLEN = 32;
    localparam int PW   = 128;
    localparam int DEPTH = 2;

    logic clk_i = 0, rsn_i = 1, kill_i = 0;
    logic up_valid_i = 0, up_ready_o, up_wr_en_i = 0, dn_ready_i = 0;
    logic [31:0] up_instr_i = 0, dn_instr_o;
    logic [XLEN-1:0] up_pc_i = 0, dn_pc_o;
    logic [4:0] up_wr_addr_i = 0, dn_wr_addr_o;
    logic [PW-1:0] up_payload_i = 0, dn_payload_o;
    logic dn_valid_o, dn_wr_en_o, dn_cache_en_o, dn_is_store_o;
    logic [2:0] occupancy_o;
`ifdef TL_PIPE_PERF_EN
    logic [31:0] stall_cnt_o;
    int unsigned m_stall;
`endif

    tl_pipe_stage #(.XLEN(XLEN), .PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .kill_i(kill_i),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o), .up_instr_i(up_instr_i),
        .up_pc_i(up_pc_i), .up_wr_addr_i(up_wr_addr_i), .up_wr_en_i(up_wr_en_i),
        .up_payload_i(up_payload_i), .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
        .dn_instr_o(dn_instr_o), .dn_pc_o(dn_pc_o), .dn_wr_addr_o(dn_wr_addr_o),
        .dn_wr_en_o(dn_wr_en_o), .dn_cache_en_o(dn_cache_en_o), .dn_is_store_o(dn_is_store_o),
        .dn_payload_o(dn_payload_o),
`ifdef TL_PIPE_PERF_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .occupancy_o(occupancy_o));

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr; logic [XLEN-1:0] pc; logic [4:0] wa;
        logic we; logic ce; logic st; logic [PW-1:0] pl;
    } ent_t;

    typedef struct {
        logic [31:0] instr; logic [4:0] wa; logic we;
        logic exp_ce; logic exp_st; logic exp_we;
    } vec_t;

    ent_t model_q[$];
    logic [XLEN-1:0] obs_q[$];
    int checks = 0, errors = 0;
    logic acc;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference classification taken directly from the opcode rules.
    function automatic ent_t make_ent(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                                      input logic [4:0] wa, input logic we, input logic [PW-1:0] pl);
        ent_t e;
        e.instr = instr; e.pc = pc; e.wa = wa; e.pl = pl;
        e.ce = (instr[6:0] == 7'h03) || (instr[6:0] == 7'h23);
        e.st = (instr[6:0] == 7'h23);
        e.we = (instr[6:0] == 7'h03) && we && (wa != 0);
        return e;
    endfunction

    // Check outputs against the model, clock one edge with the given inputs, update the model.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc,
                         input logic [4:0] wa, input logic we, input logic [PW-1:0] pl,
                         input logic rdy, input logic k, output logic accepted);
        ent_t h;
        int sz;
        up_valid_i = v; up_instr_i = instr; up_pc_i = pc; up_wr_addr_i = wa;
        up_wr_en_i = we; up_payload_i = pl; dn_ready_i = rdy; kill_i = k;
        sz = model_q.size();
        h = '{default: '0};
        if (sz > 0) h = model_q[0];
        chk("up_ready", up_ready_o, sz < DEPTH);
        chk("dn_valid", dn_valid_o, sz > 0);
        chk("occupancy", occupancy_o, sz);
        chk("dn_instr", dn_instr_o, h.instr);
        chk("dn_pc", dn_pc_o, h.pc);
        chk("dn_wr_addr", dn_wr_addr_o, h.wa);
        chk("dn_flags", {dn_wr_en_o, dn_cache_en_o, dn_is_store_o}, {h.we, h.ce, h.st});
        chk("dn_payload", dn_payload_o, h.pl);
`ifdef TL_PIPE_PERF_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        if (sz > 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
        if (dn_valid_o && rdy && !k) obs_q.push_back(dn_pc_o);
        accepted = v && (sz < DEPTH) && !k;
        @(posedge clk_i);
        if (k) model_q.delete();
        else begin
            if (sz > 0 && rdy) void'(model_q.pop_front());
            if (accepted) model_q.push_back(make_ent(instr, pc, wa, we, pl));
        end
        #1;
        up_valid_i = 0; kill_i = 0;
    endtask

    task automatic idle(input logic rdy);
        cycle(0, 0, 0, 0, 0, 0, rdy, 0, acc);
    endtask

    task automatic push1(input logic [XLEN-1:0] pc, input logic rdy);
        cycle(1, 32'h0000A083, pc, 5'd1, 1'b1, {4{$urandom}}, rdy, 0, acc);
    endtask

    task automatic reset_dut();
        rsn_i = 1;
        @(posedge clk_i); #1;
        rsn_i = 0;
        model_q.delete();
        obs_q.delete();
`ifdef TL_PIPE_PERF_EN
        m_stall = 0;
`endif
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h0000A083, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1}; // load x1
        vecs[1] = '{32'h00112023, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // store
        vecs[2] = '{32'h00000013, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}; // addi x0
        vecs[3] = '{32'h00002003, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0}; // load to x0
        vecs[4] = '{32'h0000A183, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0}; // load, decode we=0
        vecs[5] = '{32'h00112023, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0}; // store with nonzero rd
        vecs[6] = '{32'h000012B7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0}; // lui

        reset_dut();
        chk("reset_valid", dn_valid_o, 1'b0);
        chk("reset_ready", up_ready_o, 1'b1);
        chk("reset_occ", occupancy_o, 3'd0);

        // Classification table
        foreach (vecs[i]) begin
            cycle(1, vecs[i].instr, XLEN'(32'h40 + 4 * i), vecs[i].wa, vecs[i].we, PW'(i), 0, 0, acc);
            chk("cls_valid", dn_valid_o, 1'b1);
            chk("cls_cache_en", dn_cache_en_o, vecs[i].exp_ce);
            chk("cls_is_store", dn_is_store_o, vecs[i].exp_st);
            chk("cls_wr_en", dn_wr_en_o, vecs[i].exp_we);
            idle(1);
        end
        idle(0);

        // Async reset mid-cycle with two entries held
        push1(32'h10, 0);
        push1(32'h14, 0);
        chk("pre_reset_occ", occupancy_o, 3'd2);
        #2 rsn_i = 1;
        #1;
        chk("async_valid", dn_valid_o, 1'b0);
        chk("async_occ", occupancy_o, 3'd0);
        chk("async_payload", dn_payload_o, '0);
        chk("async_pc", dn_pc_o, '0);
        #1 rsn_i = 0;
        model_q.delete();
        obs_q.delete();
`ifdef TL_PIPE_PERF_EN
        m_stall = 0;
`endif
        @(posedge clk_i); #1;
        chk("post_reset_ready", up_ready_o, 1'b1);

        // Back-pressure: third push held off until the buffer drains
        push1(32'h100, 0);
        chk("bp_acc0", acc, 1'b1);
        push1(32'h104, 0);
        chk("bp_full_ready", up_ready_o, 1'b0);
        chk("bp_full_occ", occupancy_o, 3'd2);
        push1(32'h108, 0);
        chk("bp_held", acc, 1'b0);
        begin
            int n = 0;
            acc = 0;
            while (!acc && n < 8) begin push1(32'h108, 1); n++; end
            chk("bp_accept_bound", acc, 1'b1);
        end
        for (int i = 0; i < 4; i++) idle(1);
        chk("bp_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("bp_pc0", obs_q[0], 32'h100);
            chk("bp_pc1", obs_q[1], 32'h104);
            chk("bp_pc2", obs_q[2], 32'h108);
        end

        // Streaming: 16 back-to-back pushes, one output per cycle
        for (int i = 0; i < 16; i++) begin
            push1(XLEN'(32'h200 + 4 * i), 1);
            chk("stream_acc", acc, 1'b1);
            chk("stream_valid", dn_valid_o, 1'b1);
            chk("stream_pc", dn_pc_o, XLEN'(32'h200 + 4 * i));
        end
        idle(1);
        chk("stream_drained", dn_valid_o, 1'b0);

        // Kill with a full buffer and a same-cycle push
        obs_q.delete();
        push1(32'h300, 0);
        push1(32'h304, 0);
        cycle(1, 32'h0000A083, 32'hDEAD, 5'd1, 1'b1, '1, 0, 1, acc);
        chk("kill_occ", occupancy_o, 3'd0);
        chk("kill_valid", dn_valid_o, 1'b0);
        chk("kill_ready", up_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) idle(1);
        chk("kill_no_output", obs_q.size(), 0);

`ifdef TL_PIPE_PERF_EN
        reset_dut();
        push1(32'h400, 1);
        for (int i = 0; i < 5; i++) idle(0);
        chk("perf_stall5", stall_cnt_o, 32'd5);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, acc);
        chk("perf_after_kill", stall_cnt_o, 32'd5);
`endif

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            case ($urandom_range(0, 3))
                0: ins = {$urandom_range(0, 32'h1FFFFFF), 7'h03};
                1: ins = {$urandom_range(0, 32'h1FFFFFF), 7'h23};
                2: ins = {$urandom_range(0, 32'h1FFFFFF), 7'h13};
                default: ins = $urandom;
            endcase
            cycle($urandom_range(0, 3) != 0, ins, $urandom, 5'($urandom_range(0, 31)) & {5{$urandom_range(0, 3) != 0}},
                  1'($urandom_range(0, 1)), {4{$urandom}}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0, acc);
        end
        idle(1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_pipe_stage.md
Name: tl_pipe_stage

Overview:
Parametrised elastic pipeline stage between execute and the TLB/cache-lookup (TL) stage.
- Replaces the fixed stall-driven EXE/TL latch with a valid/ready handshake and a DEPTH-entry in-order buffer.
- Classifies each accepted instruction as load, store or other, and derives the cache-enable and write-enable qualifiers.
- Supports a synchronous pipeline kill.

Parameters:
XLEN, 32, width of PC.
PAYLOAD_W, 128, opaque sideband carried unchanged (cache address, store data, operands A/B, TLB-write/ID flags, packed by the instantiating stage).
DEPTH, 2, buffer entries, legal range 1..4.

Ports:
clk_i  in  1  clock, all state on rising edge
rsn_i  in  1  reset, asynchronous, active-high (asserted = 1 clears all state immediately)
kill_i  in  1  synchronous flush of all buffered entries
up_valid_i  in  1  execute presents an instruction
up_ready_o  out  1  stage can accept
up_instr_i  in  32  instruction word
up_pc_i  in  XLEN  PC
up_wr_addr_i  in  5  destination register
up_wr_en_i  in  1  integer write enable from decode
up_payload_i  in  PAYLOAD_W  sideband
dn_valid_o  out  1  head entry valid
dn_ready_i  in  1  TL consumes head
dn_instr_o  out  32  head instruction
dn_pc_o  out  XLEN  head PC
dn_wr_addr_o  out  5  head destination
dn_wr_en_o  out  1  qualified write enable
dn_cache_en_o  out  1  head is a memory op
dn_is_store_o  out  1  head is a store
dn_payload_o  out  PAYLOAD_W  head sideband
occupancy_o  out  3  entries held, 0..DEPTH

Behaviour:
- Buffer is a circular FIFO with read/write pointers modulo DEPTH and a count register. Pointers wrap from DEPTH-1 to 0.
- Push occurs when up_valid_i && up_ready_o. Pop occurs when dn_valid_o && dn_ready_i.
- up_ready_o = (count < DEPTH), driven from registers only. There is no combinational path from dn_ready_i. When full, a same-cycle pop does not enable a push.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both pointers advance.
- Latency is 1 cycle: an entry pushed at edge N gives dn_valid_o = 1 after edge N.
- Throughput:
  - DEPTH >= 2: one instruction per cycle sustained.
  - DEPTH = 1: at most one instruction every 2 cycles.
- Classification is done at push time and stored per entry; opcode = up_instr_i[6:0].
  - 0000011 (load): cache_en = 1, is_store = 0, wr_en = up_wr_en_i.
  - 0100011 (store): cache_en = 1, is_store = 1, wr_en = 0.
  - Any other opcode: cache_en = 0, is_store = 0, wr_en = 0. Non-memory results are written back elsewhere.
  - If up_wr_addr_i == 0, wr_en = 0 regardless of opcode.
- When count == 0, all dn_* outputs are 0. Stale entry contents are never exposed.
- dn_valid_o = (count != 0); occupancy_o = count.
- kill_i = 1 at an edge:
  - count and both pointers go to 0.
  - Any push in the same cycle is discarded; any pop in the same cycle is irrelevant.
  - up_ready_o = 1 on the next cycle.
- rsn_i = 1, asynchronous, including mid-transfer:
  - count, pointers and all entry storage go to 0.
  - Outputs: dn_valid_o = 0, all dn_* = 0, occupancy_o = 0.
  - up_ready_o = 1 (after the first clock edge with rsn_i low; up_ready_o is 1 combinationally from count = 0).
- rsn_i has priority over kill_i; kill_i has priority over push/pop.
- Downstream may hold dn_ready_i low indefinitely. The head and its outputs stay stable until popped.

Optional Feature:
TL_PIPE_PERF_EN:
- Defined: adds output port stall_cnt_o (32 bits). It increments on every cycle with dn_valid_o && !dn_ready_i, and saturates at 0xFFFFFFFF.
- stall_cnt_o is cleared only by rsn_i; kill_i does not clear it.
- Undefined: the port and counter are absent and there is no other behavioural difference.

Test Plan:
- Reset: assert rsn_i asynchronously mid-cycle while count = 2 -> dn_valid_o = 0 immediately, occupancy_o = 0, dn_payload_o = 0; after release up_ready_o = 1.
- Classification: push load (instr 0x0000A083, wr_addr 1, wr_en 1), then store (0x00112023), then ADDI to x0 (0x00000013) -> dn_cache_en/is_store/wr_en = 1/0/1, 1/1/0, 0/0/0.
- Back-pressure, DEPTH = 2: push 3 back-to-back with dn_ready_i = 0 -> third held off (up_ready_o = 0 after the 2nd push), occupancy_o = 2; release dn_ready_i -> in-order delivery with PCs 0x100, 0x104, 0x108.
- Streaming: dn_ready_i = 1 with 16 consecutive valid pushes -> 16 outputs on 16 consecutive cycles, order preserved, pointers wrap without loss.
- Kill: count = 2 with a push in the same cycle as kill_i -> next cycle occupancy_o = 0, dn_valid_o = 0, killed instruction never appears.
- Perf (TL_PIPE_PERF_EN): hold dn_ready_i = 0 for 5 cycles with head valid -> stall_cnt_o = 5; a following kill_i leaves it at 5.
